ddr2_cmd_sequencer: RTL
=======================

# ddr2_cmd_sequencer

Command sequencer for the x16 DDR2 SSTL18 pad interface. Runs the JEDEC power-up/initialisation sequence, then serves single-burst read/write requests with closed-page policy (ACT → RD/WR → PRE-all). It also issues periodic auto-refresh. It drives the pad interface's command inputs (cke, csbar, rasbar, casbar, webar, ba, a, odt) and the dq/dqs direction controls (ts, ri), and sits between the user-side request port and the pad interface.

## Interface
Parameters:
- T_INIT_WAIT, 200 — CKE-low NOP cycles after reset.
- T_RP, 3 — PRE to next command.
- T_RCD, 3 — ACT to RD/WR.
- T_MRD, 2 — MRS/EMRS to next command.
- T_RFC, 15 — REF to next command.
- T_REFI, 780 — auto-refresh interval.
- CL, 3 — CAS latency; write latency is CL-1.
- T_RWP, 8 — RD/WR command to PRE (covers burst plus tWR/tRTP).

Ports:
- clk in 1 — single clock; all outputs registered.
- reset in 1 — asynchronous, active-high.
- req_valid in 1 — request present.
- req_ready out 1 — request accepted when req_valid && req_ready.
- req_write in 1 — 1 = write, 0 = read.
- req_addr in 25 — {ba[24:23], row[22:10], col[9:0]}.
- init_done out 1 — initialisation complete.
- cke_o, csbar_o, rasbar_o, casbar_o, webar_o out 1 — DDR2 command.
- ba_o out 2; a_o out 13 — bank/address.
- odt_o out 1 — on-die termination.
- ts_o out 1 — 1 = dq/dqs tristated, 0 = driven.
- ri_o out 1 — read-capture window.

## Operation
- Command encodings {csbar,ras,cas,we}:
  - NOP 0111
  - ACT 0011
  - RD 0101
  - WR 0100
  - PRE 0010 (a_o[10]=1, all banks)
  - REF 0001
  - MRS 0000
- Every non-command cycle is NOP with ba_o/a_o held at 0.
- Init FSM:
  - WAIT_CKE: cke_o=0, NOP for T_INIT_WAIT cycles.
  - cke_o=1, then PRE, wait T_RP.
  - EMRS2 (ba=2, a=0), EMRS3 (ba=3, a=0), EMRS1 (ba=1, a=0), each followed by T_MRD.
  - MRS with DLL reset: ba=0, a = 0x100 | CL<<4 | 3'b010 (BL4); wait T_MRD.
  - PRE, wait T_RP.
  - REF, wait T_RFC; REF, wait T_RFC.
  - MRS without DLL reset: a = CL<<4 | 3'b010; wait T_MRD.
  - Then init_done=1 and the FSM enters IDLE.
- Main FSM: IDLE → ACT → RCD_WAIT → RW → RW_WAIT → PRE → RP_WAIT → IDLE; also IDLE → REF → RFC_WAIT → IDLE.
- ACT: ba_o=addr ba, a_o=row.
- RD/WR: ba_o=addr ba, a_o = {2'b0, 1'b0 (no auto-precharge), col}.
- req_ready=1 only in IDLE with init_done=1 and no refresh pending. Request fields are captured on acceptance.
- Refresh has priority: if refresh is pending and a request is valid in the same IDLE cycle, REF is issued and the request waits.
- Write window: ts_o=0 and odt_o=1 from the cycle after WR for CL-1+2 cycles (write latency plus BL4 = 2 clocks); otherwise ts_o=1, odt_o=0.
- Read window: ri_o=1 for 2 cycles, starting CL cycles after the RD cycle.
- Reset (including mid-burst or mid-init) returns to WAIT_CKE and forces these values:
  - cke_o=0
  - csbar_o=rasbar_o=casbar_o=webar_o=1 (deselect)
  - ba_o=0, a_o=0
  - odt_o=0, ts_o=1, ri_o=0
  - req_ready=0, init_done=0
  - all counters cleared

## Timing
- Accepted request: ACT issues 1 cycle after the acceptance edge; RD/WR issues T_RCD cycles after ACT; PRE issues T_RWP cycles after RD/WR; req_ready reasserts T_RP cycles after PRE.
- The wait counters guarantee exactly the parameter spacing; no command is issued earlier.
- The refresh counter counts clk cycles after init_done, wraps at T_REFI-1, and sets refresh_pending. refresh_pending clears when REF issues.
- If the interval elapses during a transaction, REF issues at the next IDLE. A second elapsed interval while pending does not queue a second REF.

## Configuration
- DDR2_AUTO_REFRESH_EN defined: the periodic refresh counter and the IDLE→REF path exist as above.
- Not defined: no periodic refresh logic. Only the two init REFs are issued. req_ready depends only on IDLE and init_done.

## Test plan
- Reset, run: cke_o=0 for 200 cycles; then PRE, EMRS2, EMRS3, EMRS1, MRS a=0x132, PRE, REF, REF, MRS a=0x032 at the exact spacings; init_done=1.
- Write ba=1, row=0x0ABC, col=0x010: ACT ba=1 a=0x0ABC; 3 cycles later WR a=0x010; ts_o=0/odt_o=1 for 4 cycles; PRE 8 cycles after WR.
- Read ba=2, row=5, col=0x3F8: RD 3 cycles after ACT; ri_o=1 on cycles RD+3 and RD+4; ts_o stays 1.
- Refresh interval expires while req_valid is held in IDLE: REF issued first, no ACT for 15 cycles; the request is accepted afterwards.
- Assert reset mid-write (the cycle after WR): all outputs take their reset values asynchronously; after release, the init sequence restarts from WAIT_CKE.
- DDR2_AUTO_REFRESH_EN undefined: run 2000 idle cycles after init; no REF is issued.

Source files
------------

// File: rtl/ddr2_cmd_sequencer.sv
// DDR2 x16 command sequencer: JEDEC init, closed-page single-burst RD/WR.
// Define DDR2_AUTO_REFRESH_EN to build the periodic auto-refresh logic.
module ddr2_cmd_sequencer #(
  parameter int T_INIT_WAIT = 200,
  parameter int T_RP        = 3,
  parameter int T_RCD       = 3,
  parameter int T_MRD       = 2,
  parameter int T_RFC       = 15,
  parameter int T_REFI      = 780,
  parameter int CL          = 3,
  parameter int T_RWP       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [24:0] req_addr,
  output logic        init_done,
  output logic        cke_o,
  output logic        csbar_o,
  output logic        rasbar_o,
  output logic        casbar_o,
  output logic        webar_o,
  output logic [1:0]  ba_o,
  output logic [12:0] a_o,
  output logic        odt_o,
  output logic        ts_o,
  output logic        ri_o
);

  typedef enum logic [3:0] {
    S_WAIT_CKE, S_PRE0, S_EMRS2, S_EMRS3,
    S_EMRS1, S_MRS_DLL, S_PRE1, S_REF0,
    S_REF1, S_MRS, S_IDLE, S_ACT,
    S_RW, S_PRE, S_REF, S_WAIT
  } state_t;

  localparam int CW = $clog2(T_INIT_WAIT + T_RFC + T_RWP
                             + T_RCD + T_RP + T_MRD);
  localparam int WW = $clog2(CL + 3);

  localparam logic [CW-1:0] INIT_LAST = CW'(T_INIT_WAIT - 1);
  localparam logic [CW-1:0] W_RP  = CW'(T_RP - 2);
  localparam logic [CW-1:0] W_RCD = CW'(T_RCD - 2);
  localparam logic [CW-1:0] W_MRD = CW'(T_MRD - 2);
  localparam logic [CW-1:0] W_RFC = CW'(T_RFC - 2);
  localparam logic [CW-1:0] W_RWP = CW'(T_RWP - 2);

  // Write window = write latency (CL-1) + BL4 (2 clocks).
  localparam logic [WW-1:0] WIN = WW'(CL + 1);

  localparam logic [12:0] MR_RUN = 13'((CL << 4) | 2);
  localparam logic [12:0] MR_DLL = MR_RUN | 13'h100;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  state_t          state, state_n, ret, ret_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept;
  logic            pend, pend_next;
  logic [1:0]      ba_q;
  logic [9:0]      col_q;
  logic            wr_q;
  logic [3:0]      cmd, cmd_n;
  logic [1:0]      ba_n;
  logic [12:0]     a_n;
  logic [WW-1:0]   wcnt, wcnt_n, rdc, rdc_n;

  assign {csbar_o, rasbar_o, casbar_o, webar_o} = cmd;

  // Sequence states; every command state jumps to a shared wait state.
  always_comb begin
    state_n = state;
    ret_n   = ret;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      S_WAIT_CKE: begin
        if (cnt == INIT_LAST) begin
          state_n = S_PRE0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PRE0: begin
        state_n = S_WAIT;
        ret_n   = S_EMRS2;
        cnt_n   = W_RP;
      end
      S_EMRS2: begin
        state_n = S_WAIT;
        ret_n   = S_EMRS3;
        cnt_n   = W_MRD;
      end
      S_EMRS3: begin
        state_n = S_WAIT;
        ret_n   = S_EMRS1;
        cnt_n   = W_MRD;
      end
      S_EMRS1: begin
        state_n = S_WAIT;
        ret_n   = S_MRS_DLL;
        cnt_n   = W_MRD;
      end
      S_MRS_DLL: begin
        state_n = S_WAIT;
        ret_n   = S_PRE1;
        cnt_n   = W_MRD;
      end
      S_PRE1: begin
        state_n = S_WAIT;
        ret_n   = S_REF0;
        cnt_n   = W_RP;
      end
      S_REF0: begin
        state_n = S_WAIT;
        ret_n   = S_REF1;
        cnt_n   = W_RFC;
      end
      S_REF1: begin
        state_n = S_WAIT;
        ret_n   = S_MRS;
        cnt_n   = W_RFC;
      end
      S_MRS: begin
        state_n = S_WAIT;
        ret_n   = S_IDLE;
        cnt_n   = W_MRD;
      end
      S_IDLE: begin
        if (pend) begin
          state_n = S_REF;
        end else if (req_valid && req_ready) begin
          state_n = S_ACT;
          accept  = 1'b1;
        end
      end
      S_ACT: begin
        state_n = S_WAIT;
        ret_n   = S_RW;
        cnt_n   = W_RCD;
      end
      S_RW: begin
        state_n = S_WAIT;
        ret_n   = S_PRE;
        cnt_n   = W_RWP;
      end
      S_PRE: begin
        state_n = S_WAIT;
        ret_n   = S_IDLE;
        cnt_n   = W_RP;
      end
      S_REF: begin
        state_n = S_WAIT;
        ret_n   = S_IDLE;
        cnt_n   = W_RFC;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = ret;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
    endcase
  end

  // Command/address for the cycle the next state occupies.
  always_comb begin
    cmd_n = C_NOP;
    ba_n  = '0;
    a_n   = '0;
    unique case (state_n)
      S_PRE0, S_PRE1, S_PRE: begin
        cmd_n   = C_PRE;
        a_n[10] = 1'b1;
      end
      S_EMRS2: begin
        cmd_n = C_MRS;
        ba_n  = 2'd2;
      end
      S_EMRS3: begin
        cmd_n = C_MRS;
        ba_n  = 2'd3;
      end
      S_EMRS1: begin
        cmd_n = C_MRS;
        ba_n  = 2'd1;
      end
      S_MRS_DLL: begin
        cmd_n = C_MRS;
        a_n   = MR_DLL;
      end
      S_MRS: begin
        cmd_n = C_MRS;
        a_n   = MR_RUN;
      end
      S_REF0, S_REF1, S_REF: begin
        cmd_n = C_REF;
      end
      S_ACT: begin
        cmd_n = C_ACT;
        ba_n  = req_addr[24:23];
        a_n   = req_addr[22:10];
      end
      S_RW: begin
        cmd_n = wr_q ? C_WR : C_RD;
        ba_n  = ba_q;
        a_n   = {3'b000, col_q};
      end
      default: ;
    endcase
  end

  // Data-direction windows started by the WR/RD command cycle.
  always_comb begin
    wcnt_n = wcnt;
    rdc_n  = rdc;
    if (state == S_RW && wr_q) begin
      wcnt_n = WIN;
    end else if (wcnt != '0) begin
      wcnt_n = wcnt - 1'b1;
    end
    if (state == S_RW && !wr_q) begin
      rdc_n = WIN;
    end else if (rdc != '0) begin
      rdc_n = rdc - 1'b1;
    end
  end

  // State, counters and registered pad-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_WAIT_CKE;
      ret       <= S_WAIT_CKE;
      cnt       <= '0;
      wcnt      <= '0;
      rdc       <= '0;
      cke_o     <= 1'b0;
      cmd       <= 4'b1111;
      ba_o      <= '0;
      a_o       <= '0;
      odt_o     <= 1'b0;
      ts_o      <= 1'b1;
      ri_o      <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      ret       <= ret_n;
      cnt       <= cnt_n;
      wcnt      <= wcnt_n;
      rdc       <= rdc_n;
      cke_o     <= (state_n != S_WAIT_CKE);
      cmd       <= cmd_n;
      ba_o      <= ba_n;
      a_o       <= a_n;
      odt_o     <= (wcnt_n != '0);
      ts_o      <= (wcnt_n == '0);
      ri_o      <= (rdc_n == WW'(1)) || (rdc_n == WW'(2));
      req_ready <= (state_n == S_IDLE) && !pend_next;
      init_done <= init_done || (state_n == S_IDLE);
    end
  end

  // Request fields held for the RD/WR command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ba_q  <= '0;
      col_q <= '0;
      wr_q  <= 1'b0;
    end else if (accept) begin
      ba_q  <= req_addr[24:23];
      col_q <= req_addr[9:0];
      wr_q  <= req_write;
    end
  end

`ifdef DDR2_AUTO_REFRESH_EN
  localparam int RFW = $clog2(T_REFI);
  localparam logic [RFW-1:0] REFI_LAST = RFW'(T_REFI - 1);

  logic [RFW-1:0] rcnt;
  logic           wrap;

  assign wrap      = init_done && (rcnt == REFI_LAST);
  assign pend_next = wrap || (pend && (state_n != S_REF));

  // Refresh interval counter; pending flag is sticky, never queues twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      pend <= 1'b0;
    end else begin
      pend <= pend_next;
      if (wrap) begin
        rcnt <= '0;
      end else if (init_done) begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  assign pend      = 1'b0;
  assign pend_next = 1'b0;
`endif

endmodule
